logicnet_argmax_decoder: RTL and testbench

//  Reader for the final LUT layer's packed ACT_W-bit class activations.

---
 rtl/logicnet_pkg.sv | 28 ++
 rtl/logicnet_argmax_decoder.sv | 126 ++++++++++++
 tb/tb_logicnet_argmax_decoder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared LogicNet definitions: argmax FSM state type, default activation width
// and a helper that slices one class activation out of a packed vector.
package logicnet_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

  localparam int unsigned DEFAULT_ACT_W = 2;

  // Widest vector / activation the helper handles; callers zero-extend into it.
  localparam int unsigned MAX_VEC_W = 1024;
  localparam int unsigned MAX_ACT_W = 32;

  // Return class i (act_w bits wide, at bits [i*act_w +: act_w]) of a packed vector.
  function automatic logic [MAX_ACT_W-1:0] act_slice(input logic [MAX_VEC_W-1:0] vec,
                                                     input int unsigned        i,
                                                     input int unsigned        act_w);
    logic [MAX_VEC_W-1:0] shifted;
    logic [MAX_ACT_W-1:0] mask;
    shifted = vec >> (i * act_w);
    if (act_w >= MAX_ACT_W) begin
      mask = '1;
    end else begin
      mask = (MAX_ACT_W'(1) << act_w) - MAX_ACT_W'(1);
    end
    return shifted[MAX_ACT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/logicnet_argmax_decoder.sv
// Serial argmax over the final LUT layer's packed class activations.
// One vector per valid/ready handshake; one class compared per cycle; result
// held with valid/ready until the sink takes it.
// Optional tie flag output is built when ARGMAX_TIE_FLAG_EN is defined.
module logicnet_argmax_decoder
  import logicnet_pkg::*;
#(
  parameter int unsigned N_CLASSES = 5,
  parameter int unsigned ACT_W     = DEFAULT_ACT_W,
  parameter int unsigned IDX_W     = ($clog2(N_CLASSES) > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CLASSES*ACT_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_class,
  output logic [ACT_W-1:0]           out_score
`ifdef ARGMAX_TIE_FLAG_EN
  ,
  output logic                       out_tie
`endif
);

  localparam int unsigned      VEC_W    = N_CLASSES * ACT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  argmax_state_t    state_q, state_d;
  logic [VEC_W-1:0] vec_q;
  logic [ACT_W-1:0] best_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACT_W-1:0] first_score;
  logic [ACT_W-1:0] cur_score;
  logic             accept;
  logic             last;

  // Class 0 of the incoming vector seeds best; cur_score is the class under test.
  always_comb begin
    first_score = ACT_W'(act_slice(MAX_VEC_W'(in_data), 0, ACT_W));
    cur_score   = ACT_W'(act_slice(MAX_VEC_W'(vec_q), 32'(idx_q), ACT_W));
    accept      = in_valid && (state_q == IDLE);
    last        = (idx_q == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = (N_CLASSES == 1) ? DONE : SCAN;
      end
      SCAN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, then strict-greater update while scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
    end else if (accept) begin
      vec_q      <= in_data;
      best_q     <= first_score;
      best_idx_q <= '0;
      idx_q      <= IDX_W'(1);
    end else if (state_q == SCAN) begin
      if (cur_score > best_q) begin
        best_q     <= cur_score;
        best_idx_q <= idx_q;
      end
      // Hold at the last index so the counter never wraps.
      if (!last) idx_q <= idx_q + IDX_W'(1);
    end
  end

`ifdef ARGMAX_TIE_FLAG_EN
  logic tie_q;

  // Tie flag: set on an equal compare, cleared whenever best is replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tie_q <= 1'b0;
    end else if (accept) begin
      tie_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (cur_score > best_q) begin
        tie_q <= 1'b0;
      end else if (cur_score == best_q) begin
        tie_q <= 1'b1;
      end
    end
  end
`endif

  // Outputs are driven straight from registers; only valid/ready decode state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_class = best_idx_q;
    out_score = best_q;
`ifdef ARGMAX_TIE_FLAG_EN
    out_tie   = tie_q && (state_q == DONE);
`endif
  end

endmodule

// File: tb/tb_logicnet_argmax_decoder.sv
// Directed bench for logicnet_argmax_decoder (N_CLASSES=5, ACT_W=2).
// Tie-flag checks are compiled in only when ARGMAX_TIE_FLAG_EN is defined.
module tb_logicnet_argmax_decoder;

  localparam int unsigned NC  = 5;
  localparam int unsigned AW  = 2;
  localparam int unsigned IW  = 3;
  localparam int unsigned VW  = NC * AW;
  localparam int          LAT = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [AW-1:0] out_score;
  logic          out_tie;

  int n_cmp;
  int n_fail;

  logicnet_argmax_decoder #(
    .N_CLASSES(NC),
    .ACT_W    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_score(out_score)
`ifdef ARGMAX_TIE_FLAG_EN
    ,
    .out_tie  (out_tie)
`endif
  );

`ifndef ARGMAX_TIE_FLAG_EN
  assign out_tie = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [VW-1:0] data;
    logic [IW-1:0] cls;
    logic [AW-1:0] score;
    logic          tie;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: lowest index wins ties; tie = some other class equals the max.
  function automatic vec_t ref_model(input logic [VW-1:0] d);
    vec_t r;
    logic [AW-1:0] s;
    r.data  = d;
    r.cls   = '0;
    r.score = d[AW-1:0];
    r.tie   = 1'b0;
    for (int i = 1; i < NC; i++) begin
      s = d[i*AW +: AW];
      if (s > r.score) begin
        r.score = s;
        r.cls   = IW'(i);
      end
    end
    for (int i = 0; i < NC; i++) begin
      s = d[i*AW +: AW];
      if (i != int'(r.cls) && s == r.score) r.tie = 1'b1;
    end
    return r;
  endfunction

  // Accept one vector, measure latency, check the result and complete the handshake.
  task automatic run_vec(input string name, input vec_t v);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v.data;
    tick();
    in_valid = 1'b0;
    check({name, " in_ready low after accept"}, 32'(in_ready), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({name, " latency"}, 32'(cnt), 32'(LAT));
    check({name, " out_class"}, 32'(out_class), 32'(v.cls));
    check({name, " out_score"}, 32'(out_score), 32'(v.score));
`ifdef ARGMAX_TIE_FLAG_EN
    check({name, " out_tie"}, 32'(out_tie), 32'(v.tie));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid drops"}, 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[9];
  vec_t exp_q[$];
  vec_t e;

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // data, class, score, tie (hand-computed)
    tbl[0] = '{10'h18D, 3'd1, 2'd3, 1'b0};  // 1,3,0,2,1
    tbl[1] = '{10'h2AA, 3'd0, 2'd2, 1'b1};  // all 2
    tbl[2] = '{10'h300, 3'd4, 2'd3, 1'b0};  // max at last index
    tbl[3] = '{10'h000, 3'd0, 2'd0, 1'b1};  // all zero
    tbl[4] = '{10'h3FF, 3'd0, 2'd3, 1'b1};  // all 3
    tbl[5] = '{10'h2C1, 3'd3, 2'd3, 1'b0};  // 1,0,0,3,2
    tbl[6] = '{10'h0C5, 3'd3, 2'd3, 1'b0};  // 1,1,0,3,0: early tie cleared
    tbl[7] = '{10'h30C, 3'd1, 2'd3, 1'b1};  // 0,3,0,0,3: tie after replace
    tbl[8] = '{10'h1E4, 3'd3, 2'd3, 1'b0};  // 0,1,2,3,1

    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_class", 32'(out_class), 32'd0);
    check("reset out_score", 32'(out_score), 32'd0);
    check("reset out_tie", 32'(out_tie), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-pressure: result held, new vector ignored until the sink accepts.
    in_valid = 1'b1;
    in_data  = 10'h18D;
    tick();
    in_data  = 10'h2AA;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("bp out_valid rises", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp held valid", 32'(out_valid), 32'd1);
      check("bp held class", 32'(out_class), 32'd1);
      check("bp held score", 32'(out_score), 32'd3);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp second accepted", 32'(in_ready), 32'd0);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("bp second class", 32'(out_class), 32'd0);
    check("bp second score", 32'(out_score), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset two cycles into a scan discards the vector.
    in_valid = 1'b1;
    in_data  = 10'h18D;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midscan rst out_valid", 32'(out_valid), 32'd0);
    check("midscan rst in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post rst no output", 32'(out_valid), 32'd0);
    end
    run_vec("post rst zero", tbl[3]);

    // Back-to-back with the sink always ready.
    begin
      int   k;
      int   cyc;
      int   last_acc;
      int   nres;
      logic pre_ready;
      k        = 0;
      cyc      = 0;
      last_acc = -1;
      nres     = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = tbl[5].data;
      for (int c = 0; c < 80 && nres < 6; c++) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("b2b unexpected result", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("b2b class", 32'(out_class), 32'(e.cls));
            check("b2b score", 32'(out_score), 32'(e.score));
`ifdef ARGMAX_TIE_FLAG_EN
            check("b2b tie", 32'(out_tie), 32'(e.tie));
`endif
          end
          nres++;
        end
        pre_ready = in_ready;
        tick();
        cyc++;
        if (pre_ready && in_valid) begin
          exp_q.push_back(ref_model(in_data));
          if (last_acc >= 0) check("b2b accept spacing", 32'(cyc - last_acc), 32'd6);
          last_acc = cyc;
          k++;
          if (k < 6) in_data = tbl[(k + 5) % 9].data;
          else in_valid = 1'b0;
        end
      end
      check("b2b result count", 32'(nres), 32'd6);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
